multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 38 +++
 rtl/ctrl_decode.sv | 25 ++
 rtl/multicycle_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle datapath controller.
package ctrl_pkg;

    localparam int unsigned OPC_W = 11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_LD  = 3'd1,
        CLS_ST  = 3'd2,
        CLS_CBZ = 3'd3,
        CLS_B   = 3'd4,
        CLS_ILL = 3'd5
    } iclass_e;

    localparam logic [OPC_W-1:0] OPC_ADD  = 11'b10001011000;
    localparam logic [OPC_W-1:0] OPC_SUB  = 11'b11001011000;
    localparam logic [OPC_W-1:0] OPC_AND  = 11'b10001010000;
    localparam logic [OPC_W-1:0] OPC_ORR  = 11'b10101010000;
    localparam logic [OPC_W-1:0] OPC_LDUR = 11'b11111000010;
    localparam logic [OPC_W-1:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]       OPC_CBZ_PFX = 8'b10110100;
    localparam logic [5:0]       OPC_B_PFX   = 6'b000101;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode -> instruction class decoder.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [10:0] opcode,
    output logic [2:0]  cls_c
);

    always_comb begin
        cls_c = CLS_ILL;
        if (opcode == OPC_ADD || opcode == OPC_SUB ||
            opcode == OPC_AND || opcode == OPC_ORR) begin
            cls_c = CLS_R;
        end else if (opcode == OPC_LDUR) begin
            cls_c = CLS_LD;
        end else if (opcode == OPC_STUR) begin
            cls_c = CLS_ST;
        end else if (opcode[10:3] == OPC_CBZ_PFX) begin
            cls_c = CLS_CBZ;
        end else if (opcode[10:5] == OPC_B_PFX) begin
            cls_c = CLS_B;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller: fetch/decode/exec/mem/wb sequencing with memory timeout.
// Optional performance counters enabled by defining MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        reg_we,
    output logic        reg2_loc,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic [1:0]  alu_op,
    output logic        retire,
    output logic        illegal,
    output logic        timeout,
    output logic [2:0]  state
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    // Counter only ever holds up to WAIT_LIMIT-1 pending cycles.
    localparam int unsigned WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    state_e            state_q, state_d, ret_next;
    iclass_e           cls_q, cls_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;
    logic              run_ok_q, run_ok_d;
    logic [2:0]        dec_cls_c;

    ctrl_decode u_decode (
        .opcode (opcode),
        .cls_c  (dec_cls_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cls_q     <= CLS_R;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            run_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            run_ok_q  <= run_ok_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        wait_d     = wait_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        run_ok_d   = 1'b1;
        ret_next   = run ? S_FETCH : S_IDLE;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_sel    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        reg_we     = 1'b0;
        reg2_loc   = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = ALU_ADD;
        retire     = 1'b0;

        case (state_q)
            // run_ok_q holds off the first fetch for one edge after reset release
            S_IDLE: if (run && run_ok_q) state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                cls_d = iclass_e'(dec_cls_c);
                if (iclass_e'(dec_cls_c) == CLS_ILL) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    CLS_R: begin
                        alu_op  = ALU_RTYPE;
                        state_d = S_WB;
                    end
                    CLS_LD, CLS_ST: begin
                        alu_src  = 1'b1;
                        reg2_loc = (cls_q == CLS_ST);
                        state_d  = S_MEM;
                    end
                    CLS_CBZ: begin
                        alu_op   = ALU_PASSB;
                        reg2_loc = 1'b1;
                        pc_we    = zero;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                        state_d  = ret_next;
                    end
                    CLS_B: begin
                        pc_we   = 1'b1;
                        pc_src  = 1'b1;
                        retire  = 1'b1;
                        state_d = ret_next;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_sel  = 1'b1;
                alu_src  = 1'b1;
                mem_we   = (cls_q == CLS_ST);
                reg2_loc = (cls_q == CLS_ST);
                if (mem_ready) begin
                    if (cls_q == CLS_ST) begin
                        retire  = 1'b1;
                        state_d = ret_next;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = (cls_q == CLS_LD);
                retire     = 1'b1;
                state_d    = ret_next;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // Any state change starts a fresh wait window.
        if (state_d != state_q) wait_d = '0;
    end

    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign state   = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (state_q != S_IDLE && state_q != S_HALT) cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (retire) instr_cnt_d = instr_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: per-cycle trace from an instruction-level reference model.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    localparam int LIMIT = 15;
    localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

    logic        clk = 1'b0;
    logic        rst_n, run, zero, mem_ready;
    logic [10:0] opcode;
    logic        mem_req, mem_we, mem_sel, ir_we, pc_we, pc_src, reg_we, reg2_loc;
    logic        alu_src, mem_to_reg, retire, illegal, timeout;
    logic [1:0]  alu_op;
    logic [2:0]  state;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.WAIT_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
        .reg2_loc(reg2_loc), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .alu_op(alu_op), .retire(retire), .illegal(illegal), .timeout(timeout),
        .state(state)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    typedef struct packed {
        logic [2:0] state;
        logic mem_req, mem_we, mem_sel, ir_we, pc_we, pc_src, reg_we, reg2_loc;
        logic alu_src, mem_to_reg;
        logic [1:0] alu_op;
        logic retire, illegal, timeout;
    } exp_t;

    typedef struct packed {
        logic run, zero, ready;
        logic [10:0] opc;
        exp_t e;
    } cyc_t;

    cyc_t q[$];
    bit   m_idle, m_ill, m_to;
    int   m_cyc, m_ret;

    function automatic exp_t observed();
        exp_t g;
        g = {state, mem_req, mem_we, mem_sel, ir_we, pc_we, pc_src, reg_we, reg2_loc,
             alu_src, mem_to_reg, alu_op, retire, illegal, timeout};
        return g;
    endfunction

    function automatic int classify(input logic [10:0] o);
        if (o == 11'b10001011000 || o == 11'b11001011000 ||
            o == 11'b10001010000 || o == 11'b10101010000) return K_R;
        if (o == 11'b11111000010) return K_LD;
        if (o == 11'b11111000000) return K_ST;
        if (o[10:3] == 8'b10110100) return K_CBZ;
        if (o[10:5] == 6'b000101) return K_B;
        return K_ILL;
    endfunction

    function automatic exp_t base(input logic [2:0] st);
        exp_t e;
        e = '0;
        e.state   = st;
        e.illegal = m_ill;
        e.timeout = m_to;
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic push(input exp_t e, input logic r, input logic z, input logic rdy,
                        input logic [10:0] o);
        cyc_t c;
        c.run = r; c.zero = z; c.ready = rdy; c.opc = o; c.e = e;
        q.push_back(c);
        if (e.state != S_IDLE && e.state != S_HALT) m_cyc++;
        if (e.retire) m_ret++;
    endtask

    task automatic push_halt();
        for (int i = 0; i < 4; i++) push(base(S_HALT), 1'b1, rb(), rb(), 11'($urandom));
    endtask

    // Memory handshake: ready arrives on pending cycle dly+1, or the window expires.
    task automatic mem_phase(input exp_t pend, input exp_t done, input int dly,
                             input logic rr, output bit ok);
        ok = 1'b0;
        for (int k = 1; k <= LIMIT; k++) begin
            if (k == dly + 1) begin
                push(done, done.retire ? rr : rb(), rb(), 1'b1, 11'($urandom));
                ok = 1'b1;
                return;
            end
            push(pend, rb(), rb(), 1'b0, 11'($urandom));
            if (k == LIMIT) begin
                m_to = 1'b1;
                push_halt();
                return;
            end
        end
    endtask

    task automatic push_wb(input logic ld, input logic rr);
        exp_t e;
        e = base(S_WB);
        e.reg_we = 1'b1; e.mem_to_reg = ld; e.retire = 1'b1;
        push(e, rr, rb(), rb(), 11'($urandom));
    endtask

    task automatic model_instr(input logic [10:0] opc, input logic z, input logic rr,
                               input int fd, input int md);
        int   c;
        bit   ok;
        exp_t e, p, d;
        c = classify(opc);
        if (m_idle) begin
            push(base(S_IDLE), 1'b1, rb(), rb(), 11'($urandom));
            m_idle = 1'b0;
        end
        p = base(S_FETCH); p.mem_req = 1'b1;
        d = p; d.ir_we = 1'b1; d.pc_we = 1'b1;
        mem_phase(p, d, fd, 1'b0, ok);
        if (!ok) return;
        push(base(S_DECODE), rb(), rb(), rb(), opc);
        if (c == K_ILL) begin
            m_ill = 1'b1;
            push_halt();
            return;
        end
        e = base(S_EXEC);
        case (c)
            K_R: begin
                e.alu_op = 2'b10;
                push(e, rb(), rb(), rb(), 11'($urandom));
                push_wb(1'b0, rr);
            end
            K_LD, K_ST: begin
                e.alu_src = 1'b1; e.reg2_loc = (c == K_ST);
                push(e, rb(), rb(), rb(), 11'($urandom));
                p = base(S_MEM);
                p.mem_req = 1'b1; p.mem_sel = 1'b1; p.alu_src = 1'b1;
                p.mem_we = (c == K_ST); p.reg2_loc = (c == K_ST);
                d = p; d.retire = (c == K_ST);
                mem_phase(p, d, md, rr, ok);
                if (!ok) return;
                if (c == K_LD) push_wb(1'b1, rr);
            end
            K_CBZ: begin
                e.alu_op = 2'b01; e.reg2_loc = 1'b1; e.pc_we = z; e.pc_src = 1'b1;
                e.retire = 1'b1;
                push(e, rr, z, rb(), 11'($urandom));
            end
            default: begin
                e.pc_we = 1'b1; e.pc_src = 1'b1; e.retire = 1'b1;
                push(e, rr, rb(), rb(), 11'($urandom));
            end
        endcase
        m_idle = !rr;
    endtask

    task automatic run_queue(input int max_n);
        cyc_t c;
        exp_t g;
        int   n;
        n = 0;
        while (q.size() > 0 && n < max_n) begin
            c = q.pop_front();
            @(negedge clk);
            run = c.run; zero = c.zero; mem_ready = c.ready; opcode = c.opc;
            #1;
            g = observed();
            n_checks++;
            if (g !== c.e) begin
                n_fail++;
                $display("FAIL trace t=%0t: got %h (state %0d) required %h (state %0d)",
                         $time, g, g.state, c.e, c.e.state);
            end
            n++;
        end
    endtask

    task automatic check_perf();
`ifdef MULTICYCLE_CTRL_PERF_EN
        @(posedge clk);
        #1;
        n_checks++;
        if (cycle_cnt !== 32'(m_cyc) || instr_cnt !== 32'(m_ret)) begin
            n_fail++;
            $display("FAIL perf_counts: cycle %0d instr %0d required %0d %0d",
                     cycle_cnt, instr_cnt, m_cyc, m_ret);
        end
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = '0;
        q.delete();
        m_idle = 1'b1; m_ill = 1'b0; m_to = 1'b0; m_cyc = 0; m_ret = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        bit found;
        #3;
        rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = OPC_ADD;
        #1;
        n_checks++;
        if (observed() !== exp_t'(0)) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", observed());
        end
`ifdef MULTICYCLE_CTRL_PERF_EN
        n_checks++;
        if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_perf: got %0d %0d required 0 0", cycle_cnt, instr_cnt);
        end
`endif
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (observed() !== exp_t'(0)) begin
            n_fail++;
            $display("FAIL first_edge_idle: got %h required 0", observed());
        end
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk);
            #1;
            if (mem_req === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL first_fetch: mem_req %b required 1 within 4 cycles", mem_req);
        end
    endtask

    task automatic test_add();
        do_reset();
        model_instr(OPC_ADD, 1'b0, 1'b0, 0, 0);
        run_queue(1000);
        check_perf();
    endtask

    task automatic test_ldur();
        do_reset();
        model_instr(OPC_LDUR, rb(), 1'b1, 0, 3);
        model_instr(OPC_STUR, rb(), 1'b0, 2, 1);
        run_queue(1000);
        check_perf();
    endtask

    task automatic test_cbz();
        do_reset();
        model_instr({OPC_CBZ_PFX, 3'($urandom)}, 1'b0, 1'b1, 0, 0);
        model_instr({OPC_CBZ_PFX, 3'($urandom)}, 1'b1, 1'b0, 1, 0);
        model_instr({OPC_B_PFX, 5'($urandom)}, 1'b0, 1'b0, 0, 0);
        run_queue(1000);
        check_perf();
    endtask

    task automatic test_timeout();
        do_reset();
        model_instr(OPC_ADD, 1'b0, 1'b0, 20, 0);
        run_queue(1000);
        do_reset();
        model_instr(OPC_ADD, 1'b0, 1'b0, 14, 0);
        run_queue(1000);
        do_reset();
        model_instr(OPC_LDUR, 1'b0, 1'b1, 0, 14);
        model_instr(OPC_LDUR, 1'b0, 1'b0, 0, 15);
        run_queue(1000);
        check_perf();
    endtask

    task automatic test_illegal();
        do_reset();
        model_instr(11'b00000000000, 1'b0, 1'b1, 0, 0);
        run_queue(1000);
        check_perf();
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        model_instr(OPC_STUR, 1'b0, 1'b1, 0, 10);
        run_queue(6);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (observed() !== exp_t'(0)) begin
            n_fail++;
            $display("FAIL reset_mid_mem: got %h required 0", observed());
        end
`ifdef MULTICYCLE_CTRL_PERF_EN
        n_checks++;
        if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_mem_perf: got %0d %0d required 0 0", cycle_cnt, instr_cnt);
        end
`endif
    endtask

    task automatic test_random();
        logic [10:0] opc;
        int fd, md;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 7))
                0: opc = OPC_ADD;
                1: opc = OPC_SUB;
                2: opc = OPC_AND;
                3: opc = OPC_ORR;
                4: opc = OPC_LDUR;
                5: opc = OPC_STUR;
                6: opc = {OPC_CBZ_PFX, 3'($urandom)};
                default: opc = {OPC_B_PFX, 5'($urandom)};
            endcase
            fd = ($urandom_range(0, 9) == 0) ? LIMIT - 1 : int'($urandom_range(0, 4));
            md = ($urandom_range(0, 9) == 0) ? LIMIT - 1 : int'($urandom_range(0, 4));
            model_instr(opc, rb(), ($urandom_range(0, 3) != 0), fd, md);
            run_queue(1000);
        end
        check_perf();
    endtask

    // Write strobes must be mutually exclusive in every cycle.
    always begin
        @(negedge clk);
        #2;
        if (rst_n === 1'b1) begin
            n_checks++;
            if (32'(ir_we) + 32'(reg_we) + 32'(mem_we) > 32'd1) begin
                n_fail++;
                $display("FAIL strobe_exclusive: ir_we %b reg_we %b mem_we %b required at most one",
                         ir_we, reg_we, mem_we);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = '0;
        m_idle = 1'b1; m_ill = 1'b0; m_to = 1'b0; m_cyc = 0; m_ret = 0;
        test_reset();
        test_add();
        test_ldur();
        test_cbz();
        test_timeout();
        test_illegal();
        test_reset_mid_mem();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
